// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package if_prefetch_unit_pkg;

    typedef enum logic [0:0] {
        StBoot  = 1'b0,
        StFetch = 1'b1
    } fetch_state_e;

    localparam int unsigned InstBytes = 4;

endpackage

// File: rtl/if_prefetch_fifo.sv
// {pc,inst} prefetch buffer: power-of-two ring with synchronous flush and occupancy count.
module if_prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: multi-outstanding valid/ready fetch, prefetch buffer, redirect flush.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter int unsigned     ILEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h8000_0000),
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic            fetch_en;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   drop_q, drop_d;

    logic            redirect, req_fire, rsp_accept, push, pop;
    logic [XLEN-1:0] redirect_aligned;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [XLEN+ILEN-1:0] fifo_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StBoot;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: state_d = StFetch;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        fetch_en = (state_q == StFetch);
    end

    assign redirect         = redirect_valid && fetch_en;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Credits cover both in-flight requests and buffered entries, so a push never finds it full.
    assign req_valid = fetch_en && !redirect_valid
                    && (32'(outst_q) < MAX_OUTST)
                    && ((32'(outst_q) + 32'(fifo_count)) < DEPTH);
    assign req_addr  = pc_q;
    assign req_fire  = req_valid && req_ready;

    assign rsp_accept = rsp_valid && fetch_en;
    assign push       = rsp_accept && (drop_q == '0) && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        drop_d    = drop_q;
        outst_d   = outst_q;

        case ({req_fire, rsp_accept})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (redirect) begin
            pc_d      = redirect_aligned;
            resp_pc_d = redirect_aligned;
            // Every request still in flight after this cycle belongs to the old stream.
            drop_d    = outst_q - OW'(rsp_accept);
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(InstBytes);
            if (push)     resp_pc_d = resp_pc_q + XLEN'(InstBytes);
            if (rsp_accept && (drop_q != '0)) drop_d = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    if_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wdata ({resp_pc_q, rsp_inst}),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst_o     = inst_valid ? fifo_head[ILEN-1:0] : '0;
    assign inst_pc    = inst_valid ? fifo_head[XLEN+ILEN-1:ILEN] : '0;

endmodule
